// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: stage payload structs, statistics type, occupancy helper
package pipeline_pkg;

   localparam int PIPE_STAT_W = 32;
   typedef logic [PIPE_STAT_W-1:0] pipe_stat_t;
   localparam pipe_stat_t PIPE_STAT_MAX = '1;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SLL    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_SLT    = 4'd8,
      ALU_SLTU   = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      MEM_NONE = 3'd0,
      MEM_LB   = 3'd1,
      MEM_LH   = 3'd2,
      MEM_LW   = 3'd3,
      MEM_SB   = 3'd4,
      MEM_SH   = 3'd5,
      MEM_SW   = 3'd6
   } mem_op_e;

   typedef enum logic [1:0] {
      WB_SRC_ALU = 2'd0,
      WB_SRC_MEM = 2'd1,
      WB_SRC_PC4 = 2'd2
   } wb_src_e;

   // Stage payloads; instantiators pass $bits(<payload>) as the register WIDTH.
   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_payload_t;

   typedef struct packed {
      word_t     pc;
      word_t     rs1_val;
      word_t     rs2_val;
      word_t     imm;
      reg_addr_t rd;
      alu_op_e   alu_op;
      mem_op_e   mem_op;
      wb_src_e   wb_src;
      logic      reg_write;
      logic      use_imm;
   } decode_payload_t;

   typedef struct packed {
      word_t     pc;
      word_t     alu_result;
      word_t     store_data;
      reg_addr_t rd;
      mem_op_e   mem_op;
      wb_src_e   wb_src;
      logic      reg_write;
   } execute_payload_t;

   typedef struct packed {
      word_t     pc;
      word_t     alu_result;
      word_t     mem_rdata;
      reg_addr_t rd;
      wb_src_e   wb_src;
      logic      reg_write;
   } memory_payload_t;

   typedef struct packed {
      reg_addr_t rd;
      word_t     wb_data;
      logic      reg_write;
   } writeback_payload_t;

   localparam int FETCH_PAYLOAD_W     = $bits(fetch_payload_t);
   localparam int DECODE_PAYLOAD_W    = $bits(decode_payload_t);
   localparam int EXECUTE_PAYLOAD_W   = $bits(execute_payload_t);
   localparam int MEMORY_PAYLOAD_W    = $bits(memory_payload_t);
   localparam int WRITEBACK_PAYLOAD_W = $bits(writeback_payload_t);

   // Width needed to count 0..depth valid slices.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - one valid+payload register slice with load, flush clear and optional payload zeroing
module pipe_slice #(
   parameter int WIDTH      = 32,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_load,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic             o_valid_next,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Next valid is exported so the parent can popcount the post-edge state.
   always_comb begin
      o_valid_next = r_valid;
      if (reset || i_flush) begin
         o_valid_next = 1'b0;
      end else if (i_load) begin
         o_valid_next = i_valid;
      end
   end

   always_ff @(posedge clock) begin
      r_valid <= o_valid_next;
      if (reset) begin
         r_data <= '0;
      end else if (i_flush) begin
         if (CLEAR_DATA) begin
            r_data <= '0;
         end
      end else if (i_load) begin
         if (i_valid) begin
            r_data <= i_data;
         end else if (CLEAR_DATA) begin
            r_data <= '0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic DEPTH-slice pipeline register with backpressure and flush
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
   import pipeline_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 1,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [occ_width(DEPTH)-1:0] occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output pipe_stat_t                  stall_cycles,
   output pipe_stat_t                  bubble_cycles
`endif
);

   localparam int OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] w_v;
   logic [DEPTH-1:0] w_v_next;
   logic [DEPTH-1:0] w_load;
   logic [DEPTH-1:0] w_src_v;
   logic [WIDTH-1:0] w_src_d [DEPTH];
   logic [WIDTH-1:0] w_d     [DEPTH];
   logic [OCC_W-1:0] w_occ_next;
   logic [OCC_W-1:0] r_occ;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      if (i == 0) begin : g_head
         assign w_src_v[i] = in_valid;
         assign w_src_d[i] = in_data;
      end else begin : g_link
         assign w_src_v[i] = w_v[i-1];
         assign w_src_d[i] = w_d[i-1];
      end

      pipe_slice #(
         .WIDTH      (WIDTH),
         .CLEAR_DATA (CLEAR_DATA)
      ) u_slice (
         .clock        (clock),
         .reset        (reset),
         .i_flush      (flush),
         .i_load       (w_load[i]),
         .i_valid      (w_src_v[i]),
         .i_data       (w_src_d[i]),
         .o_valid      (w_v[i]),
         .o_valid_next (w_v_next[i]),
         .o_data       (w_d[i])
      );
   end

   // Ready ripples from the output back to slice 0 so a full pipe advances without a bubble.
   always_comb begin : p_ready_chain
      logic w_carry;
      w_load  = '0;
      w_carry = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_load[i] = !w_v[i] || w_carry;
         w_carry   = w_load[i];
      end
   end

   always_comb begin
      w_occ_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ_next = w_occ_next + OCC_W'(w_v_next[i]);
      end
   end

   always_ff @(posedge clock) begin
      r_occ <= w_occ_next;
   end

   assign in_ready  = w_load[0] && !flush && !reset;
   assign out_valid = w_v[DEPTH-1];
   assign out_data  = w_d[DEPTH-1];
   assign occupancy = r_occ;

`ifdef PIPE_STAGE_STATS_EN
   pipe_stat_t r_stall_cycles;
   pipe_stat_t r_bubble_cycles;

   // Saturating counters; flush deliberately leaves them running.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cycles  <= '0;
         r_bubble_cycles <= '0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cycles != PIPE_STAT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + pipe_stat_t'(1);
         end
         if (!out_valid && (r_bubble_cycles != PIPE_STAT_MAX)) begin
            r_bubble_cycles <= r_bubble_cycles + pipe_stat_t'(1);
         end
      end
   end

   assign stall_cycles  = r_stall_cycles;
   assign bubble_cycles = r_bubble_cycles;
`else
   // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against an entry-position queue model
module tb_pipe_stage_reg;

   localparam int WIDTH      = 32;
   localparam int DEPTH      = 3;
   localparam bit CLEAR_DATA = 1'b1;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]      stall_cycles;
   logic [31:0]      bubble_cycles;
`endif

   always #5 clock = ~clock;

   pipe_stage_reg #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .CLEAR_DATA (CLEAR_DATA)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cycles  (stall_cycles),
      .bubble_cycles (bubble_cycles)
`endif
   );

   // Model: in-flight entries oldest first, each with its slice position.
   typedef struct {
      logic [WIDTH-1:0] data;
      int               pos;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   known = 1'b0;
   longint m_stall  = 0;
   longint m_bubble = 0;

   logic             obs_ir;
   logic             obs_ov;
   logic [WIDTH-1:0] obs_od;
   int               obs_occ;
   longint           obs_stall;
   longint           obs_bubble;

   logic [WIDTH-1:0] outlog[$];
   int               outcyc[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] id, input logic ordy, output logic acc);
      int               np[$];
      ent_t             nq[$];
      logic             exp_ir;
      logic             exp_ov;
      logic [WIDTH-1:0] exp_od;
      @(negedge clock);
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
      exp_od = exp_ov ? q[0].data : '0;
      // An entry moves unless the slot ahead stays occupied; the head leaves on out_ready.
      for (int k = 0; k < q.size(); k++) begin
         if (k == 0) begin
            np.push_back((q[0].pos == DEPTH - 1) ? (ordy ? DEPTH : DEPTH - 1) : q[0].pos + 1);
         end else begin
            np.push_back((np[k-1] == q[k].pos + 1) ? q[k].pos : q[k].pos + 1);
         end
      end
      exp_ir = !rst && !fl && !((q.size() > 0) && (np[q.size()-1] == 0));
      obs_ir  = in_ready;
      obs_ov  = out_valid;
      obs_od  = out_data;
      obs_occ = int'(occupancy);
      check("in_ready", in_ready, exp_ir);
      if (known) begin
         check("out_valid", out_valid, exp_ov);
         check("out_data", out_data, exp_od);
         check("occupancy", occupancy, q.size());
`ifdef PIPE_STAGE_STATS_EN
         obs_stall  = stall_cycles;
         obs_bubble = bubble_cycles;
         check("stall_cycles", stall_cycles, m_stall);
         check("bubble_cycles", bubble_cycles, m_bubble);
`endif
         if (exp_ov && ordy && !rst) begin
            outlog.push_back(out_data);
            outcyc.push_back(cyc);
         end
      end
      acc = iv && exp_ir;
      @(posedge clock);
      if (rst) begin
         m_stall  = 0;
         m_bubble = 0;
      end else begin
         m_stall  += (exp_ov && !ordy) ? 1 : 0;
         m_bubble += exp_ov ? 0 : 1;
      end
      if (rst || fl) begin
         q.delete();
      end else begin
         for (int k = 0; k < q.size(); k++) begin
            if (np[k] < DEPTH) nq.push_back('{q[k].data, np[k]});
         end
         if (acc) nq.push_back('{id, 0});
         q = nq;
      end
      if (rst) known = 1'b1;
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] vals[4];
      logic             acc;
      int               idx;
      int               first_acc;
      int               peak;
      longint           snap_s;
      longint           snap_b;

      // Reset
      step(1, 0, 1, 32'h99, 1, acc);
      check("rst_in_ready", obs_ir, 0);
      step(1, 0, 1, 32'h99, 1, acc);
      check("rst_in_ready2", obs_ir, 0);
      step(0, 0, 0, '0, 1, acc);
      check("post_rst_out_valid", obs_ov, 0);
      check("post_rst_out_data", obs_od, 0);
      check("post_rst_occupancy", obs_occ, 0);
      check("post_rst_in_ready", obs_ir, 1);

      // Streaming 1..4 with out_ready held high
      vals = '{32'h1, 32'h2, 32'h3, 32'h4};
      outlog.delete(); outcyc.delete();
      idx = 0; first_acc = -1;
      for (int n = 0; n < 20; n++) begin
         if (idx < 4) begin
            step(0, 0, 1, vals[idx], 1, acc);
            if (acc && first_acc < 0) first_acc = cyc - 1;
            if (acc) idx++;
         end else begin
            step(0, 0, 0, '0, 1, acc);
         end
      end
      check("stream_count", outlog.size(), 4);
      if (outlog.size() == 4) begin
         check("stream_latency", outcyc[0] - first_acc, DEPTH);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("stream_data%0d", k), outlog[k], vals[k]);
            check($sformatf("stream_cycle%0d", k), outcyc[k] - outcyc[0], k);
         end
      end

      // Backpressure: three accepted, fourth held upstream
      vals = '{32'hA, 32'hB, 32'hC, 32'hD};
      outlog.delete(); outcyc.delete();
      idx = 0;
      for (int n = 0; n < 8; n++) begin
         step(0, 0, 1, vals[idx], 0, acc);
         if (acc) idx++;
      end
      check("bp_accepted", idx, 3);
      check("bp_in_ready", obs_ir, 0);
      check("bp_occupancy", obs_occ, 3);
      for (int n = 0; n < 12; n++) begin
         if (idx < 4) begin
            step(0, 0, 1, vals[idx], 1, acc);
            if (acc) idx++;
         end else begin
            step(0, 0, 0, '0, 1, acc);
         end
      end
      check("bp_drain_count", outlog.size(), 4);
      if (outlog.size() == 4) begin
         for (int k = 0; k < 4; k++) check($sformatf("bp_data%0d", k), outlog[k], vals[k]);
      end

      // Bubbles: valid pattern 1,0,1
      outlog.delete(); outcyc.delete();
      peak = 0;
      step(0, 0, 1, 32'h5, 1, acc);
      step(0, 0, 0, 32'h6, 1, acc);
      step(0, 0, 1, 32'h7, 1, acc);
      for (int n = 0; n < 6; n++) begin
         step(0, 0, 0, '0, 1, acc);
         if (obs_occ > peak) peak = obs_occ;
      end
      check("bubble_count", outlog.size(), 2);
      if (outlog.size() == 2) begin
         check("bubble_first", outlog[0], 32'h5);
         check("bubble_second", outlog[1], 32'h7);
         check("bubble_gap", outcyc[1] - outcyc[0], 2);
      end
      check("bubble_peak_occ", peak, 2);

      // Flush with a full pipe and 0xEE offered
      outlog.delete(); outcyc.delete();
      step(0, 0, 1, 32'h11, 0, acc);
      step(0, 0, 1, 32'h22, 0, acc);
      step(0, 0, 1, 32'h33, 0, acc);
      step(0, 1, 1, 32'hEE, 0, acc);
      check("flush_occ_before", obs_occ, 3);
      check("flush_in_ready", obs_ir, 0);
      step(0, 0, 0, '0, 0, acc);
      check("flush_occ_after", obs_occ, 0);
      check("flush_out_valid", obs_ov, 0);
      check("flush_out_data", obs_od, 0);
      for (int n = 0; n < 4; n++) step(0, 0, 0, '0, 1, acc);
      check("flush_nothing_out", outlog.size(), 0);

`ifdef PIPE_STAGE_STATS_EN
      // Five stalled cycles, a flush, then four empty cycles
      step(0, 0, 1, 32'h41, 0, acc);
      step(0, 0, 1, 32'h42, 0, acc);
      step(0, 0, 1, 32'h43, 0, acc);
      snap_s = m_stall;
      snap_b = m_bubble;
      for (int n = 0; n < 5; n++) step(0, 0, 0, '0, 0, acc);
      step(0, 1, 0, '0, 1, acc);
      for (int n = 0; n < 4; n++) step(0, 0, 0, '0, 1, acc);
      step(0, 0, 0, '0, 1, acc);
      check("stats_stall5", obs_stall, snap_s + 5);
      check("stats_bubble4", obs_bubble, snap_b + 4);
`else
      snap_s = 0;
      snap_b = 0;
`endif

      // Randomised traffic with occasional flush and reset
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), acc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register: a chain of DEPTH register slices, each carrying a WIDTH-bit payload plus a valid bit, with ready/valid backpressure and synchronous flush. It generalises the fixed fetch/decode/execute/memory/writeback registers by adding:

- stall via backpressure;
- bubble tracking;
- occupancy reporting;
- configurable depth.

It sits between any two pipeline stages, with stage control and datapath fields packed into the payload.

## Interface
- WIDTH, 32, payload width in bits (>= 1)
- DEPTH, 1, number of register slices (>= 1)
- CLEAR_DATA, 1, 1: payload registers zeroed on reset/flush; 0: only valid bits cleared
- clock  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all in-flight entries
- in_valid  input  1  upstream presents payload
- in_ready  output  1  slice 0 can accept this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  last slice holds a valid entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  WIDTH  payload of last slice
- occupancy  output  $clog2(DEPTH+1)  number of valid slices

## Operation
- Slices are numbered 0 (input side) to DEPTH-1 (output side). Each slice holds v[i] and d[i].
- Advance rule:
  - Slice DEPTH-1 can load when !v[DEPTH-1] || out_ready.
  - Slice i < DEPTH-1 can load when !v[i] || load[i+1].
  - The ready chain is combinational, so a full pipe moves one entry per cycle with no bubble.
- in_ready = load[0] && !flush.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- When slice i loads, it takes v[i-1]/d[i-1]; slice 0 takes in_valid/in_data.
  - A loading slice whose source is invalid becomes invalid (a bubble). Its payload then follows CLEAR_DATA: zeroed if 1, else unchanged.
  - A slice that cannot load holds v and d (stall).
- Flush:
  - Next cycle, all v = 0 and occupancy = 0.
  - If CLEAR_DATA, all d = 0.
  - The input offered during the flush cycle is not accepted (in_ready = 0).
  - out_valid during the flush cycle still reflects the current state. A downstream transfer in that same cycle is legal and is the final one.
- Reset: same effect as flush, applied unconditionally (d zeroed regardless of CLEAR_DATA).
- occupancy is a registered popcount of v, updated every edge.

## Timing
- Reset values: out_valid 0, out_data 0, occupancy 0. in_ready is 0 while reset is high, and 1 in the first cycle after reset deasserts.
- Latency: an entry accepted at edge N appears on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles through the registers. This holds with no backpressure.
- Throughput: 1 entry/cycle with out_ready held high.
- Full pipe with out_ready = 0: in_ready = 0, and all state holds indefinitely.
- Full pipe with out_ready = 1 and in_valid = 1: simultaneous accept and consume, and occupancy is unchanged.
- Empty pipe: out_valid = 0. out_data is zero if CLEAR_DATA, else stale.
- Precedence: reset > flush > normal advance.
- Reset or flush mid-stall discards all entries, with no partial draining.
- Payload is never combinationally passed from in_data to out_data, even when DEPTH = 1.

## Configuration
- PIPE_STAGE_STATS_EN defined: two extra outputs, each 32 bits and saturating at 0xFFFF_FFFF.
  - stall_cycles increments each cycle in which out_valid && !out_ready.
  - bubble_cycles increments each cycle in which !out_valid and reset is low.
  - Both clear on reset only; flush does not clear them.
- PIPE_STAGE_STATS_EN undefined: the ports and counters are absent, and the interface is exactly the list above.

## Structure
- Shared package pipeline_pkg gains:
  - an occupancy-width helper function;
  - the constant PIPE_STAT_W = 32;
  - typedef pipe_stat_t.
- Stage payload struct types (fetch/decode/execute/memory/writeback fields) live in pipeline_pkg. Instantiators pass their bit width as WIDTH.
- One sub-module, pipe_slice: a single valid+payload register with load, clear and CLEAR_DATA. The top generates DEPTH instances plus the ready chain and occupancy logic.

## Test plan
- Reset with WIDTH=32, DEPTH=3, CLEAR_DATA=1: after reset, out_valid=0, out_data=0, occupancy=0, and in_ready=1 on the first post-reset cycle.
- Streaming: feed 0x1, 0x2, 0x3, 0x4 on consecutive cycles with out_ready=1. out_valid rises 3 cycles after the first accept, and out_data is 0x1..0x4 on consecutive cycles.
- Backpressure: hold out_ready=0 and present 0xA, 0xB, 0xC, 0xD. The first three are accepted, in_ready falls, occupancy=3, and 0xD is held upstream. Raising out_ready drains 0xA, 0xB, 0xC, 0xD in order with no loss or duplication.
- Bubbles: present in_valid in the pattern 1,0,1 with values 0x5, -, 0x7. The output shows 0x5, one invalid cycle, then 0x7; occupancy peaks at 2.
- Flush with occupancy=3 and in_valid=1 carrying 0xEE: next cycle occupancy=0, out_valid=0, out_data=0, and 0xEE is not accepted.
- With PIPE_STAGE_STATS_EN: 5 stalled cycles followed by an empty pipe of 4 cycles gives stall_cycles=5 and bubble_cycles=4. A flush leaves both counters unchanged.
